// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int DEFAULT_PC_BITS  = 12;
  localparam int DEFAULT_CNT_BITS = 16;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: sequential step, absolute or PC-relative branch,
// plus detection of the last memory address.
module pc_next_calc #(
  parameter int PC_BITS = 12
) (
  input  logic [PC_BITS-1:0] pc,
  input  logic               br_taken,
  input  logic               br_abs,
  input  logic [PC_BITS-1:0] br_target,
  output logic [PC_BITS-1:0] next_pc,
  output logic               at_end
);

  localparam logic [PC_BITS-1:0] PC_ONE = {{(PC_BITS-1){1'b0}}, 1'b1};

  always_comb begin
    next_pc = pc + PC_ONE;
    if (br_taken) begin
      // Relative targets are two's-complement; the add wraps modulo 2**PC_BITS.
      next_pc = br_abs ? br_target : (pc + br_target);
    end
  end

  assign at_end = (pc == {PC_BITS{1'b1}});

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter controller: IDLE/RUN/DONE sequencing with stall, branch,
// halt, saturating retire counter and sticky end-of-memory overrun flag.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                  PC_BITS  = DEFAULT_PC_BITS,
  parameter logic [PC_BITS-1:0]  START_PC = '0,
  parameter int                  CNT_BITS = DEFAULT_CNT_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                halt,
  input  logic                br_taken,
  input  logic                br_abs,
  input  logic [PC_BITS-1:0]  br_target,
  output logic [PC_BITS-1:0]  pc,
  output logic                fetch_valid,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [CNT_BITS-1:0] instr_count
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  fetch_state_t        state_q, state_d;
  logic [PC_BITS-1:0]  pc_q, pc_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                overrun_q, overrun_d;

  logic [PC_BITS-1:0]  calc_pc;
  logic                at_end;
  logic [CNT_BITS-1:0] count_inc;

  pc_next_calc #(
    .PC_BITS(PC_BITS)
  ) u_pc_next_calc (
    .pc        (pc_q),
    .br_taken  (br_taken),
    .br_abs    (br_abs),
    .br_target (br_target),
    .next_pc   (calc_pc),
    .at_end    (at_end)
  );

  assign count_inc = (count_q == {CNT_BITS{1'b1}}) ? count_q : (count_q + CNT_ONE);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = START_PC;
          count_d   = '0;
          overrun_d = 1'b0;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = DONE;
          count_d = count_inc;
        end else if (!stall) begin
          count_d = count_inc;
          if (br_taken) begin
            pc_d = calc_pc;
          end else if (at_end) begin
            // Falling off the last address ends the program; pc stays put.
            state_d   = DONE;
            overrun_d = 1'b1;
          end else begin
            pc_d = calc_pc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign pc          = pc_q;
  assign busy        = (state_q == RUN);
  assign fetch_valid = (state_q == RUN) && !stall;
  assign done        = (state_q == DONE);
  assign overrun     = overrun_q;
  assign instr_count = count_q;

endmodule
